// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared state encodings and parameter defaults for mem_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int unsigned C_READ_DELAY = 10;
    localparam int unsigned C_AW         = 16;
    localparam int unsigned C_DW         = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ_WAIT = 2'd1,
        ST_WRITE     = 2'd2,
        ST_RESP      = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter2
// Brief   : Two-input round-robin arbiter with its last-granted register.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic accept_i,
    output logic i_gnt_o,
    output logic d_gnt_o
);

    // 1 = D was granted last; reset leaves I as last so D wins the first tie.
    logic last_d_q;

    assign d_gnt_o = d_req_i & (~i_req_i | ~last_d_q);
    assign i_gnt_o = i_req_i & ~d_gnt_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else if (accept_i && (i_req_i || d_req_i)) begin
            last_d_q <= d_gnt_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Arbitrates I-cache reads and D-cache reads/write-backs onto one
//           fixed-latency memory port.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned READ_DELAY = C_READ_DELAY,
    parameter int unsigned AW         = C_AW,
    parameter int unsigned DW         = C_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic          m_rden,
    output logic          m_wren,
    input  logic [DW-1:0] m_rdata
);

    localparam logic [7:0] C_RD = 8'(READ_DELAY);

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          accept_w;
    logic          i_gnt_w, d_gnt_w;
    logic          rden_w, wren_w, i_ack_w, d_ack_w;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_req_i  (i_req),
        .d_req_i  (d_req),
        .accept_i (accept_w),
        .i_gnt_o  (i_gnt_w),
        .d_gnt_o  (d_gnt_w)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        accept_w = 1'b0;
        rden_w   = 1'b0;
        wren_w   = 1'b0;
        i_ack_w  = 1'b0;
        d_ack_w  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    accept_w = 1'b1;
                    owner_d  = d_gnt_w ? OWN_D : OWN_I;
                    addr_d   = d_gnt_w ? d_addr : i_addr;
                    wdata_d  = d_wdata;
                    cnt_d    = 8'd0;
                    state_d  = (d_gnt_w && d_we) ? ST_WRITE : ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == C_RD) begin
                    rden_w  = 1'b1;
                    rdata_d = m_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: begin
                wren_w  = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                i_ack_w = (owner_q == OWN_I);
                d_ack_w = (owner_q == OWN_D);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_I;
            cnt_q   <= 8'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes and acks are forced low while reset is held, even before the first edge.
    assign i_ack   = i_ack_w & ~rst;
    assign d_ack   = d_ack_w & ~rst;
    assign m_rden  = rden_w  & ~rst;
    assign m_wren  = wren_w  & ~rst;
    assign rdata   = rdata_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed self-checking bench for mem_arbiter (READ_DELAY 10 and 1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] m_rdata = '0;

    logic          i_ack, d_ack, m_rden, m_wren;
    logic [DW-1:0] rdata, m_wdata;
    logic [AW-1:0] m_addr;
    logic          i_ack1, d_ack1, m_rden1, m_wren1;
    logic [DW-1:0] rdata1, m_wdata1;
    logic [AW-1:0] m_addr1;

    int checks = 0;
    int errors = 0;

    // Results gathered by watch()
    int fr, fw, fi, fd, nr, nw, ni, nd, nboth;
    logic [DW-1:0] rd_ack, wa_data;
    logic [AW-1:0] wa_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.READ_DELAY(10), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rden(m_rden), .m_wren(m_wren), .m_rdata(m_rdata)
    );

    mem_arbiter #(.READ_DELAY(1), .AW(AW), .DW(DW)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack1),
        .rdata(rdata1), .m_addr(m_addr1), .m_wdata(m_wdata1),
        .m_rden(m_rden1), .m_wren(m_wren1), .m_rdata(m_rdata)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Observe max cycles after the launch cycle; requesters drop req on seeing ack.
    task automatic watch(input int max, input int drop_at);
        fr = 0; fw = 0; fi = 0; fd = 0;
        nr = 0; nw = 0; ni = 0; nd = 0; nboth = 0;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            if (k == drop_at) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
            if (m_rden && m_wren) nboth++;
            if (m_rden) begin
                nr++;
                if (fr == 0) fr = k;
            end
            if (m_wren) begin
                nw++;
                if (fw == 0) begin
                    fw = k; wa_addr = m_addr; wa_data = m_wdata;
                end
            end
            if (i_ack) begin
                ni++;
                if (fi == 0) begin
                    fi = k; rd_ack = rdata;
                end
                i_req = 1'b0;
            end
            if (d_ack) begin
                nd++;
                if (fd == 0) fd = k;
                d_req = 1'b0;
            end
        end
    endtask

    initial begin
        int seq [3];
        int nseq;
        int fr1, fi1;
        logic [DW-1:0] rd1;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_strobes", {i_ack, d_ack, m_rden, m_wren}, 4'b0000);
        check_val("rst_rdata", rdata, 0);
        check_val("rst_maddr", m_addr, 0);
        check_val("rst_mwdata", m_wdata, 0);
        rst = 1'b0;

        // Lone I read
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0040; m_rdata = 32'hDEADBEEF;
        watch(16, 0);
        check_val("iread_rden_cyc", fr, 11);
        check_val("iread_rden_cnt", nr, 1);
        check_val("iread_ack_cyc", fi, 12);
        check_val("iread_ack_cnt", ni, 1);
        check_val("iread_dack_cnt", nd, 0);
        check_val("iread_rdata", rd_ack, 32'hDEADBEEF);
        check_val("iread_maddr", m_addr, 16'h0040);
        check_val("iread_wren_cnt", nw, 0);

        // Lone D write-back
        i_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h1234; d_wdata = 32'hCAFEF00D;
        watch(8, 0);
        check_val("dwr_wren_cyc", fw, 1);
        check_val("dwr_wren_cnt", nw, 1);
        check_val("dwr_addr", wa_addr, 16'h1234);
        check_val("dwr_data", wa_data, 32'hCAFEF00D);
        check_val("dwr_ack_cyc", fd, 2);
        check_val("dwr_ack_cnt", nd, 1);
        check_val("dwr_iack_cnt", ni, 0);
        check_val("dwr_rden_cnt", nr, 0);
        check_val("dwr_rdata_held", rdata, 32'hDEADBEEF);
        d_we = 1'b0;

        // Withdrawal of a read request mid-transaction
        i_req = 1'b1; i_addr = 16'h0080; m_rdata = 32'h12345678;
        watch(24, 3);
        check_val("wd_ack_cyc", fi, 12);
        check_val("wd_ack_cnt", ni, 1);
        check_val("wd_rden_cnt", nr, 1);
        check_val("wd_rdata", rd_ack, 32'h12345678);

        // Simultaneous requests held after reset: D, I, D
        do_reset();
        i_req = 1'b1; i_addr = 16'h0100;
        d_req = 1'b1; d_addr = 16'h0200; d_we = 1'b0;
        nseq = 0; nboth = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (i_ack && d_ack) nboth++;
            if (i_ack && nseq < 3) begin seq[nseq] = 1; nseq++; end
            if (d_ack && nseq < 3) begin seq[nseq] = 2; nseq++; end
        end
        i_req = 1'b0; d_req = 1'b0;
        check_val("alt_count", nseq, 3);
        check_val("alt_first_d", seq[0], 2);
        check_val("alt_second_i", seq[1], 1);
        check_val("alt_third_d", seq[2], 2);
        check_val("alt_dual_ack", nboth, 0);

        // Reset in the middle of a read
        repeat (3) @(negedge clk);
        i_req = 1'b1; i_addr = 16'h0040; m_rdata = 32'hDEADBEEF;
        repeat (5) @(negedge clk);
        rst = 1'b1; i_req = 1'b0;
        @(negedge clk);
        check_val("mrst_strobes", {i_ack, d_ack, m_rden, m_wren}, 4'b0000);
        check_val("mrst_state", 64'(dut.state_q), 64'(ST_IDLE));
        check_val("mrst_rdata", rdata, 0);
        rst = 1'b0;
        watch(20, 0);
        check_val("mrst_no_rden", nr, 0);
        check_val("mrst_no_ack", ni + nd, 0);
        i_req = 1'b1;
        watch(16, 0);
        check_val("mrst_next_rden", fr, 11);
        check_val("mrst_next_ack", fi, 12);
        check_val("mrst_next_rdata", rd_ack, 32'hDEADBEEF);

        // READ_DELAY=1 instance
        do_reset();
        i_req = 1'b1; i_addr = 16'h0010; m_rdata = 32'hA5A5A5A5;
        fr1 = 0; fi1 = 0; rd1 = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (m_rden1 && fr1 == 0) fr1 = k;
            if (i_ack1 && fi1 == 0) begin
                fi1 = k; rd1 = rdata1; i_req = 1'b0;
            end
        end
        check_val("rd1_rden_cyc", fr1, 2);
        check_val("rd1_ack_cyc", fi1, 3);
        check_val("rd1_rdata", rd1, 32'hA5A5A5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
